// File: rtl/uart_rx_pkg.sv
// Shared widths and limits for the UART receive path.
package uart_rx_pkg;
   localparam int DATA_W      = 8;
   localparam int ERR_CNT_W   = 8;
   localparam int ERR_CNT_MAX = 255;
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for uart_rx_fifo: one write port, asynchronous read, no reset.
module uart_rx_fifo_mem
   import uart_rx_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT byte FIFO behind the UART receiver with sticky overflow flag.
// Define UART_RX_FIFO_ERR_CNT_EN to add the saturating error-frame counter.
module uart_rx_fifo
   import uart_rx_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     data_valid,
   input  logic [DATA_W-1:0]        P_DATA,
   input  logic                     stp_chk_en,
   input  logic                     par_err,
   input  logic                     stp_err,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     overflow,
   input  logic                     ovf_clr
`ifdef UART_RX_FIFO_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0]     err_cnt,
   input  logic                     err_clr
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        push;
   logic        pop;
   logic        drop;

   // Extra MSB on each pointer separates full from empty.
   assign level     = wptr - rptr;
   assign full      = (level == (AW+1)'(DEPTH));
   assign out_valid = (level != '0);
   assign pop       = out_valid & out_ready;
   assign push      = data_valid & (~full | pop);
   assign drop      = data_valid & full & ~pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (drop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

   uart_rx_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push & ~rst),
      .waddr (wptr[AW-1:0]),
      .wdata (P_DATA),
      .raddr (rptr[AW-1:0]),
      .rdata (out_data)
   );

`ifdef UART_RX_FIFO_ERR_CNT_EN
   logic err_frame;

   assign err_frame = stp_chk_en & (par_err | stp_err);

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (err_frame) begin
         if (err_clr)
            err_cnt <= ERR_CNT_W'(1);
         else if (err_cnt != ERR_CNT_W'(ERR_CNT_MAX))
            err_cnt <= err_cnt + 1'b1;
      end else if (err_clr) begin
         err_cnt <= '0;
      end
   end
`else
   logic unused_err;

   assign unused_err = stp_chk_en ^ par_err ^ stp_err;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo (DEPTH=16 and DEPTH=4).
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       data_valid;
   logic [7:0] P_DATA;
   logic       stp_chk_en;
   logic       par_err;
   logic       stp_err;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic [4:0] level;
   logic       full;
   logic       overflow;
   logic       ovf_clr;
   logic [7:0] err_cnt;
   logic       err_clr;

   logic       d4_dv;
   logic [7:0] d4_data;
   logic       d4_rdy;
   logic       d4_ovalid;
   logic [7:0] d4_odata;
   logic [2:0] d4_level;
   logic       d4_full;
   logic       d4_ovf;

   int checks   = 0;
   int failures = 0;

   logic [7:0] q  [$];
   logic [7:0] q4 [$];
   int         ecnt;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_valid (data_valid),
      .P_DATA     (P_DATA),
      .stp_chk_en (stp_chk_en),
      .par_err    (par_err),
      .stp_err    (stp_err),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .level      (level),
      .full       (full),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
`ifdef UART_RX_FIFO_ERR_CNT_EN
      ,
      .err_cnt    (err_cnt),
      .err_clr    (err_clr)
`endif
   );

`ifndef UART_RX_FIFO_ERR_CNT_EN
   assign err_cnt = 8'd0;
`endif

   uart_rx_fifo #(.DEPTH(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .data_valid (d4_dv),
      .P_DATA     (d4_data),
      .stp_chk_en (1'b0),
      .par_err    (1'b0),
      .stp_err    (1'b0),
      .out_ready  (d4_rdy),
      .out_valid  (d4_ovalid),
      .out_data   (d4_odata),
      .level      (d4_level),
      .full       (d4_full),
      .overflow   (d4_ovf),
      .ovf_clr    (1'b0)
`ifdef UART_RX_FIFO_ERR_CNT_EN
      ,
      .err_cnt    (),
      .err_clr    (1'b0)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      data_valid = 1'b1;
      P_DATA     = b;
      if (q.size() < 16) q.push_back(b);
      tick();
      data_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         out_ready = 1'b1;
         chk("drain_valid", {31'd0, out_valid}, 32'd1);
         if (q.size() > 0) chk("drain_order", {24'd0, out_data}, {24'd0, q.pop_front()});
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic err_frame(input logic clr);
      stp_chk_en = 1'b1;
      stp_err    = 1'b1;
      err_clr    = clr;
`ifdef UART_RX_FIFO_ERR_CNT_EN
      if (clr) ecnt = 1;
      else if (ecnt < 255) ecnt++;
`endif
      tick();
      stp_chk_en = 1'b0;
      stp_err    = 1'b0;
      err_clr    = 1'b0;
   endtask

   initial begin
      logic [9:0] pu_pat;
      logic [9:0] rd_pat;
      rst = 1'b1; data_valid = 0; P_DATA = 0; stp_chk_en = 0;
      par_err = 0; stp_err = 0; out_ready = 0; ovf_clr = 0; err_clr = 0;
      d4_dv = 0; d4_data = 0; d4_rdy = 0; ecnt = 0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_level", {27'd0, level}, 0);
      chk("rst_valid", {31'd0, out_valid}, 0);
      chk("rst_full", {31'd0, full}, 0);
      chk("rst_ovf", {31'd0, overflow}, 0);
      chk("rst_errcnt", {24'd0, err_cnt}, 0);

      // single byte latency
      push(8'hA5);
      chk("a5_valid", {31'd0, out_valid}, 1);
      chk("a5_data", {24'd0, out_data}, 32'hA5);
      chk("a5_level", {27'd0, level}, 1);
      drain(1);
      chk("a5_level0", {27'd0, level}, 0);
      chk("a5_valid0", {31'd0, out_valid}, 0);

      // fill then overflow
      for (int i = 0; i < 16; i++) push(8'(i));
      chk("fill_full", {31'd0, full}, 1);
      chk("fill_level", {27'd0, level}, 16);
      chk("fill_ovf0", {31'd0, overflow}, 0);
      push(8'hFF);
      chk("ovf_set", {31'd0, overflow}, 1);
      chk("ovf_level", {27'd0, level}, 16);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk("ovf_clr", {31'd0, overflow}, 0);
      ovf_clr = 1'b1; push(8'hEE); ovf_clr = 1'b0;
      chk("ovf_set_wins", {31'd0, overflow}, 1);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      drain(16);
      chk("drain_empty", {31'd0, out_valid}, 0);

      // full with simultaneous push and pop
      for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
      data_valid = 1'b1; P_DATA = 8'h55; out_ready = 1'b1;
      chk("pp_data", {24'd0, out_data}, {24'd0, q.pop_front()});
      q.push_back(8'h55);
      tick();
      data_valid = 1'b0; out_ready = 1'b0;
      chk("pp_level", {27'd0, level}, 16);
      chk("pp_full", {31'd0, full}, 1);
      chk("pp_ovf", {31'd0, overflow}, 0);
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      void'(q.pop_front());
      out_ready = 1'b1;
      chk("stall_data", {24'd0, out_data}, {24'd0, q[0]});
      out_ready = 1'b0; tick();
      chk("stall_hold", {24'd0, out_data}, {24'd0, q[0]});
      drain(15);
      chk("pp_last_empty", {27'd0, level}, 0);

      // error frames
      for (int i = 0; i < 300; i++) err_frame(1'b0);
      chk("err_sat", {24'd0, err_cnt}, ecnt);
      chk("err_level", {27'd0, level}, 0);
`ifdef UART_RX_FIFO_ERR_CNT_EN
      chk("err_255", {24'd0, err_cnt}, 255);
      err_clr = 1'b1; tick(); err_clr = 1'b0; ecnt = 0;
      chk("err_clr", {24'd0, err_cnt}, 0);
      err_frame(1'b0); err_frame(1'b1);
      chk("err_inc_wins", {24'd0, err_cnt}, 1);
`endif

      // mid-stream reset
      for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
      push(8'h99);
      drain(11);
      err_frame(1'b0);
      chk("pre_rst_level", {27'd0, level}, 5);
      chk("pre_rst_ovf", {31'd0, overflow}, 1);
      rst = 1'b1; data_valid = 1'b1; P_DATA = 8'h99; out_ready = 1'b1;
      ovf_clr = 1'b0;
      tick();
      rst = 1'b0; data_valid = 1'b0; out_ready = 1'b0;
      q.delete(); ecnt = 0;
      chk("mrst_level", {27'd0, level}, 0);
      chk("mrst_valid", {31'd0, out_valid}, 0);
      chk("mrst_ovf", {31'd0, overflow}, 0);
      chk("mrst_err", {24'd0, err_cnt}, 0);
      push(8'h3C);
      chk("post_rst_data", {24'd0, out_data}, 32'h3C);
      drain(1);

      // DEPTH=4 wrap with interleaved traffic
      pu_pat = 10'b1110111111;
      rd_pat = 10'b1111010000;
      for (int c = 0; c < 10; c++) begin
         logic pop_m;
         d4_dv   = pu_pat[c];
         d4_data = 8'(8'hC0 + c);
         d4_rdy  = rd_pat[c];
         pop_m   = d4_rdy && (q4.size() > 0);
         if (pop_m) chk("w4_data", {24'd0, d4_odata}, {24'd0, q4.pop_front()});
         if (d4_dv && (q4.size() < 4)) q4.push_back(d4_data);
         tick();
         chk("w4_level", {29'd0, d4_level}, q4.size());
      end
      d4_dv = 1'b0;
      while (q4.size() > 0) begin
         d4_rdy = 1'b1;
         chk("w4_drain", {24'd0, d4_odata}, {24'd0, q4.pop_front()});
         tick();
      end
      d4_rdy = 1'b0;
      chk("w4_empty", {31'd0, d4_ovalid}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, 16, number of byte entries; power of two, 4..256.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port data_valid  input  1  one-cycle strobe: good frame byte on P_DATA.
REQ-005 SHALL have port P_DATA  input  8  received byte; sampled only when data_valid=1.
REQ-006 SHALL have port stp_chk_en  input  1  one-cycle strobe marking end of each frame check.
REQ-007 SHALL have port par_err  input  1  parity error of current frame; qualified by stp_chk_en.
REQ-008 SHALL have port stp_err  input  1  stop-bit error of current frame; qualified by stp_chk_en.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 SHALL have port out_valid  output  1  out_data holds oldest byte.
REQ-011 SHALL have port out_data  output  8  oldest byte, first-word-fall-through.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH.
REQ-013 SHALL have port full  output  1  level==DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky: a good byte was dropped.
REQ-015 SHALL have port ovf_clr  input  1  clears overflow.
REQ-016 SHALL have ports err_cnt  output  8  and err_clr  input  1  when UART_RX_FIFO_ERR_CNT_EN defined (REQ-032).

Function
REQ-017 SHALL push P_DATA when data_valid=1 and (full=0 or pop occurs same cycle).
REQ-018 SHALL pop when out_valid=1 and out_ready=1; out_valid = (level!=0), combinational from registered state.
REQ-019 SHALL present a pushed byte on out_data one cycle after the push edge (push-to-valid latency 1).
REQ-020 SHALL, on simultaneous push and pop, leave level unchanged; when full, accept the push (slot freed by pop).
REQ-021 SHALL, on push with level==0, not pop that cycle (out_valid=0); level becomes 1.
REQ-022 SHALL, on data_valid=1 with full=1 and no pop, drop the byte, leave pointers/level unchanged, set overflow.
REQ-023 SHALL hold overflow until ovf_clr=1; set wins over clear in the same cycle.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; level derived from pointer difference with extra wrap bit.
REQ-025 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-026 SHALL treat stp_chk_en=1 with (par_err|stp_err)=1 as one error frame; data_valid is 0 for such frames and nothing is pushed.
REQ-027 SHALL increment err_cnt by 1 per error frame, saturating at 255; err_clr zeroes it; increment wins over clear in same cycle (result 1).

Reset
REQ-028 SHALL, with rst=1 at a clock edge, set pointers to 0, level=0, out_valid=0, full=0, overflow=0, err_cnt=0.
REQ-029 SHALL ignore data_valid, out_ready, ovf_clr, err_clr during reset cycles; a mid-stream reset discards all stored bytes.
REQ-030 SHALL not require storage array reset; out_data content is don't-care while out_valid=0.

Configuration
REQ-031 SHALL use macro UART_RX_FIFO_ERR_CNT_EN to compile in the error counter.
REQ-032 SHALL, with macro defined, provide err_cnt/err_clr per REQ-016/027; without it, omit both ports and counter logic, and ignore par_err/stp_err/stp_chk_en.

Structure
REQ-033 SHALL take DATA_W=8, ERR_CNT_W=8 and ERR_CNT_MAX=255 from shared package uart_rx_pkg.
REQ-034 SHALL place storage in sub-module uart_rx_fifo_mem (1 write port, asynchronous read port, no reset).

Verification
REQ-035 SHALL cover: push 0xA5 (empty) -> next cycle out_valid=1, out_data=0xA5, level=1; pop -> level=0, out_valid=0.
REQ-036 SHALL cover: 16 pushes 0x00..0x0F, then 17th push 0xFF with no pop -> full=1, overflow=1, 0xFF never read; reads return 0x00..0x0F in order.
REQ-037 SHALL cover: full FIFO, push 0x55 and pop same cycle -> level stays 16, 0x55 read last, overflow=0.
REQ-038 SHALL cover: 300 frames with stp_chk_en=1, stp_err=1 -> err_cnt=255, level=0; err_clr -> err_cnt=0.
REQ-039 SHALL cover: 5 bytes stored, overflow=1, rst=1 one cycle -> level=0, out_valid=0, overflow=0, err_cnt=0; next push 0x3C reads back 0x3C.
REQ-040 SHALL cover: DEPTH=4, 10 interleaved push/pop cycles spanning pointer wrap -> data order preserved, level matches model every cycle.
